test_result_monitor: RTL and testbench

Parametrised pass/fail monitor for FPGA bring-up of the MIPS core. It observes the core's data-memory write bus and decides the test verdict. It latches diagnostic data for the first failing write, applies a cycle watchdog and drives the board status LEDs. It sits beside top in the FPGA top level and generalises the fixed single-address check to configurable addresses and data, strict or lenient modes, timeout detection and a heartbeat LED.

---
 rtl/test_result_monitor_if.sv | 16 +
 rtl/test_result_monitor.sv | 124 ++++++++++++
 tb/tb_test_result_monitor.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/test_result_monitor_if.sv
// Data-memory write bus observed by the test result monitor.
//   memwrite  : write strobe from the core
//   dataadr   : write address
//   writedata : write data
// master drives the bus (core side), slave observes it (monitor side).
interface test_result_monitor_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              memwrite;
  logic [ADDR_W-1:0] dataadr;
  logic [DATA_W-1:0] writedata;

  modport master (output memwrite, dataadr, writedata);
  modport slave  (input  memwrite, dataadr, writedata);
endinterface

// File: rtl/test_result_monitor.sv
// Pass/fail monitor for MIPS core bring-up. Watches the data-memory write
// bus, decides the verdict, latches the first failing write, runs a cycle
// watchdog and drives the status LEDs.
// Ports:
//   ph2         : clock, rising edge
//   reset       : asynchronous active-low reset
//   bus         : write bus (slave modport)
//   outputleds  : {pass, fail, timeout, heartbeat}
//   state       : 00 IDLE, 01 RUN, 10 PASS, 11 FAIL or TIMEOUT
//   write_count : writes accepted in RUN, saturating
//   fail_addr   : address of the first failing write
//   fail_data   : data of the first failing write
//   done        : verdict reached
//
// state | meaning
// IDLE  | first edge after reset release, bus ignored
// RUN   | watching writes, watchdog counting
// PASS  | expected value written to PASS_ADDR (sticky)
// END   | failing write or watchdog expiry (sticky), is_to_q tells which
module test_result_monitor #(
  parameter int              ADDR_W    = 32,
  parameter int              DATA_W    = 32,
  parameter logic [ADDR_W-1:0] PASS_ADDR = ADDR_W'(32'h14),
  parameter logic [DATA_W-1:0] PASS_DATA = DATA_W'(21),
  parameter int              STRICT    = 1,
  parameter int              TIMEOUT   = 1048576,
  parameter int              CNT_W     = 21,
  parameter int              WCNT_W    = 16,
  parameter int              HB_BIT    = 22
) (
  input  logic                  ph2,
  input  logic                  reset,
  test_result_monitor_if.slave  bus,
  output logic [3:0]            outputleds,
  output logic [1:0]            state,
  output logic [WCNT_W-1:0]     write_count,
  output logic [ADDR_W-1:0]     fail_addr,
  output logic [DATA_W-1:0]     fail_data,
  output logic                  done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_PASS = 2'b10,
    S_END  = 2'b11
  } state_t;

  state_t            state_q, state_d;
  logic              is_to_q, is_to_d;
  logic              latch_fail;
  logic              count_wr;
  logic [CNT_W-1:0]  cyc_cnt;
  logic [HB_BIT:0]   hb_cnt;
  logic              addr_hit, data_hit, tmo_hit;

  assign addr_hit = (bus.dataadr == PASS_ADDR);
  assign data_hit = (bus.writedata == PASS_DATA);
  // cyc_cnt holds the number of RUN edges already seen, so it reads
  // TIMEOUT-1 on the TIMEOUT-th RUN edge.
  assign tmo_hit  = (TIMEOUT != 0) && (cyc_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge ph2 or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      is_to_q     <= 1'b0;
      cyc_cnt     <= '0;
      write_count <= '0;
      fail_addr   <= '0;
      fail_data   <= '0;
      hb_cnt      <= '0;
    end else begin
      state_q <= state_d;
      is_to_q <= is_to_d;
      hb_cnt  <= hb_cnt + 1'b1;
      if (state_q == S_RUN && state_d == S_RUN)
        cyc_cnt <= cyc_cnt + 1'b1;
      else
        cyc_cnt <= '0;
      if (count_wr && !(&write_count))
        write_count <= write_count + 1'b1;
      if (latch_fail) begin
        fail_addr <= bus.dataadr;
        fail_data <= bus.writedata;
      end
    end
  end

  // Write verdicts are checked before the watchdog so a terminating write
  // on the last allowed cycle still wins.
  always_comb begin
    state_d    = state_q;
    is_to_d    = is_to_q;
    latch_fail = 1'b0;
    count_wr   = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_RUN;
      S_RUN: begin
        count_wr = bus.memwrite;
        if (bus.memwrite && addr_hit && data_hit) begin
          state_d = S_PASS;
        end else if (bus.memwrite && (addr_hit || STRICT != 0)) begin
          state_d    = S_END;
          latch_fail = 1'b1;
        end else if (tmo_hit) begin
          state_d = S_END;
          is_to_d = 1'b1;
        end
      end
      default: state_d = state_q;
    endcase
  end

  always_comb begin
    state         = state_q;
    done          = (state_q == S_PASS) || (state_q == S_END);
    outputleds[3] = (state_q == S_PASS);
    outputleds[2] = (state_q == S_END) && !is_to_q;
    outputleds[1] = (state_q == S_END) && is_to_q;
    // A finished board shows a steady heartbeat LED.
    outputleds[0] = done | hb_cnt[HB_BIT];
  end

endmodule

// File: tb/tb_test_result_monitor.sv
module tb_test_result_monitor;

  logic ph2 = 1'b0;
  logic reset = 1'b0;
  always #5 ph2 = ~ph2;

  logic        mw  = 1'b0;
  logic [31:0] adr = '0;
  logic [31:0] dat = '0;
  logic        sel = 1'b0;

  test_result_monitor_if #(.ADDR_W(32), .DATA_W(32)) bus_s ();
  test_result_monitor_if #(.ADDR_W(32), .DATA_W(32)) bus_l ();
  assign bus_s.memwrite  = mw;
  assign bus_s.dataadr   = adr;
  assign bus_s.writedata = dat;
  assign bus_l.memwrite  = mw;
  assign bus_l.dataadr   = adr;
  assign bus_l.writedata = dat;

  logic [3:0]  leds_s, leds_l;
  logic [1:0]  st_s, st_l;
  logic [15:0] wc_s;
  logic [2:0]  wc_l;
  logic [31:0] fa_s, fa_l, fd_s, fd_l;
  logic        done_s, done_l;

  // strict, 16-cycle watchdog
  test_result_monitor #(.STRICT(1), .TIMEOUT(16), .CNT_W(5), .HB_BIT(2)) u_strict (
    .ph2(ph2), .reset(reset), .bus(bus_s), .outputleds(leds_s), .state(st_s),
    .write_count(wc_s), .fail_addr(fa_s), .fail_data(fd_s), .done(done_s));

  // lenient, watchdog disabled, 3-bit write counter
  test_result_monitor #(.STRICT(0), .TIMEOUT(0), .CNT_W(5), .WCNT_W(3), .HB_BIT(2)) u_lenient (
    .ph2(ph2), .reset(reset), .bus(bus_l), .outputleds(leds_l), .state(st_l),
    .write_count(wc_l), .fail_addr(fa_l), .fail_data(fd_l), .done(done_l));

  logic [3:0]  o_leds;
  logic [1:0]  o_st;
  logic [15:0] o_wc;
  logic [31:0] o_fa, o_fd;
  logic        o_done;
  always_comb begin
    o_leds = sel ? leds_l : leds_s;
    o_st   = sel ? st_l : st_s;
    o_wc   = sel ? {13'b0, wc_l} : wc_s;
    o_fa   = sel ? fa_l : fa_s;
    o_fd   = sel ? fd_l : fd_s;
    o_done = sel ? done_l : done_s;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        sel;
    logic        mw;
    logic [31:0] a;
    logic [31:0] d;
    logic [1:0]  st;
    logic [2:0]  l;
    logic        dn;
    logic [15:0] wc;
    logic [31:0] fa;
    logic [31:0] fd;
    string       nm;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic rst, input logic s, input logic w,
                              input logic [31:0] a, input logic [31:0] d,
                              input logic [1:0] st, input logic [2:0] l,
                              input logic dn, input logic [15:0] wc,
                              input logic [31:0] fa, input logic [31:0] fd,
                              input string nm);
    vec_t v;
    v.rst = rst; v.sel = s; v.mw = w; v.a = a; v.d = d; v.st = st; v.l = l;
    v.dn = dn; v.wc = wc; v.fa = fa; v.fd = fd; v.nm = nm;
    vecs.push_back(v);
  endfunction

  task automatic chk_reset_state(input string nm);
    chk({nm, "_state"}, {30'b0, o_st}, 32'h0);
    chk({nm, "_leds"},  {28'b0, o_leds}, 32'h0);
    chk({nm, "_done"},  {31'b0, o_done}, 32'h0);
    chk({nm, "_wc"},    {16'b0, o_wc}, 32'h0);
    chk({nm, "_faddr"}, o_fa, 32'h0);
    chk({nm, "_fdata"}, o_fd, 32'h0);
  endtask

  // starts and ends on a falling edge, reset released there
  task automatic reset_dut();
    mw = 1'b0; adr = '0; dat = '0;
    reset = 1'b0;
    repeat (2) @(negedge ph2);
    chk_reset_state("rst");
    reset = 1'b1;
  endtask

  task automatic step(input logic w, input logic [31:0] a, input logic [31:0] d);
    mw = w; adr = a; dat = d;
    @(posedge ph2);
    #1;
  endtask

  initial begin
    //   rst sel mw addr   data   st     leds   dn wc fa     fd
    add(1, 0, 0, 32'h0,  32'd0,  2'b01, 3'b000, 0, 0, 32'h0,  32'd0,  "a_idle");
    add(0, 0, 0, 32'h0,  32'd0,  2'b01, 3'b000, 0, 0, 32'h0,  32'd0,  "a_run1");
    add(0, 0, 0, 32'h0,  32'd0,  2'b01, 3'b000, 0, 0, 32'h0,  32'd0,  "a_run2");
    add(0, 0, 1, 32'h14, 32'd21, 2'b10, 3'b100, 1, 1, 32'h0,  32'd0,  "a_pass");
    add(0, 0, 1, 32'h20, 32'd5,  2'b10, 3'b100, 1, 1, 32'h0,  32'd0,  "a_sticky");
    add(1, 0, 1, 32'h14, 32'd21, 2'b01, 3'b000, 0, 0, 32'h0,  32'd0,  "b_idle_ignored");
    add(0, 0, 1, 32'h20, 32'd5,  2'b11, 3'b010, 1, 1, 32'h20, 32'd5,  "b_fail");
    add(0, 0, 1, 32'h14, 32'd21, 2'b11, 3'b010, 1, 1, 32'h20, 32'd5,  "b_sticky");
    add(1, 1, 0, 32'h0,  32'd0,  2'b01, 3'b000, 0, 0, 32'h0,  32'd0,  "c_idle");
    add(0, 1, 1, 32'h20, 32'd5,  2'b01, 3'b000, 0, 1, 32'h0,  32'd0,  "c_w1");
    add(0, 1, 1, 32'h24, 32'd6,  2'b01, 3'b000, 0, 2, 32'h0,  32'd0,  "c_w2");
    add(0, 1, 0, 32'h0,  32'd0,  2'b01, 3'b000, 0, 2, 32'h0,  32'd0,  "c_gap");
    add(0, 1, 1, 32'h14, 32'd21, 2'b10, 3'b100, 1, 3, 32'h0,  32'd0,  "c_pass");
    add(0, 1, 1, 32'h14, 32'd22, 2'b10, 3'b100, 1, 3, 32'h0,  32'd0,  "c_sticky");
    add(1, 1, 0, 32'h0,  32'd0,  2'b01, 3'b000, 0, 0, 32'h0,  32'd0,  "e_idle");
    add(0, 1, 1, 32'h30, 32'd1,  2'b01, 3'b000, 0, 1, 32'h0,  32'd0,  "e_other");
    add(0, 1, 1, 32'h14, 32'd7,  2'b11, 3'b010, 1, 2, 32'h14, 32'd7,  "e_fail");
    add(1, 0, 0, 32'h0,  32'd0,  2'b01, 3'b000, 0, 0, 32'h0,  32'd0,  "d_idle");
    add(0, 0, 1, 32'h14, 32'd22, 2'b11, 3'b010, 1, 1, 32'h14, 32'd22, "d_fail");

    @(negedge ph2);
    foreach (vecs[i]) begin
      sel = vecs[i].sel;
      if (vecs[i].rst) reset_dut();
      step(vecs[i].mw, vecs[i].a, vecs[i].d);
      chk({vecs[i].nm, "_state"}, {30'b0, o_st}, {30'b0, vecs[i].st});
      chk({vecs[i].nm, "_leds"},  {29'b0, o_leds[3:1]}, {29'b0, vecs[i].l});
      chk({vecs[i].nm, "_done"},  {31'b0, o_done}, {31'b0, vecs[i].dn});
      chk({vecs[i].nm, "_wc"},    {16'b0, o_wc}, {16'b0, vecs[i].wc});
      chk({vecs[i].nm, "_faddr"}, o_fa, vecs[i].fa);
      chk({vecs[i].nm, "_fdata"}, o_fd, vecs[i].fd);
      @(negedge ph2);
    end

    // asynchronous reset from FAIL, between clock edges
    sel = 1'b0;
    reset = 1'b0;
    #2;
    chk_reset_state("async_rst");

    // watchdog expiry on the 16th RUN edge (strict DUT)
    sel = 1'b0;
    reset_dut();
    for (int k = 0; k < 16; k++) begin
      step(1'b0, 32'h0, 32'd0);
      @(negedge ph2);
    end
    chk("tmo_before_state", {30'b0, st_s}, 32'h1);
    chk("tmo_before_done", {31'b0, done_s}, 32'h0);
    step(1'b0, 32'h0, 32'd0);
    chk("tmo_state", {30'b0, st_s}, 32'h3);
    chk("tmo_leds", {29'b0, leds_s[3:1]}, 32'h1);
    chk("tmo_done", {31'b0, done_s}, 32'h1);
    chk("tmo_faddr", fa_s, 32'h0);
    chk("lenient_no_tmo_state", {30'b0, st_l}, 32'h1);
    @(negedge ph2);
    repeat (20) begin
      step(1'b0, 32'h0, 32'd0);
      @(negedge ph2);
    end
    chk("tmo_sticky_state", {30'b0, st_s}, 32'h3);
    chk("lenient_no_tmo_late", {30'b0, st_l}, 32'h1);

    // pass write on the watchdog's last edge wins
    reset_dut();
    for (int k = 0; k < 16; k++) begin
      step(1'b0, 32'h0, 32'd0);
      @(negedge ph2);
    end
    step(1'b1, 32'h14, 32'd21);
    chk("prio_pass_state", {30'b0, st_s}, 32'h2);
    chk("prio_pass_leds", {29'b0, leds_s[3:1]}, 32'h4);
    @(negedge ph2);

    // failing write on the watchdog's last edge is a FAIL, not a timeout
    reset_dut();
    for (int k = 0; k < 16; k++) begin
      step(1'b0, 32'h0, 32'd0);
      @(negedge ph2);
    end
    step(1'b1, 32'h20, 32'd5);
    chk("prio_fail_leds", {29'b0, leds_s[3:1]}, 32'h2);
    chk("prio_fail_faddr", fa_s, 32'h20);
    @(negedge ph2);

    // write counter saturates (lenient DUT, 3-bit)
    sel = 1'b1;
    reset_dut();
    step(1'b0, 32'h0, 32'd0);
    @(negedge ph2);
    for (int k = 1; k <= 9; k++) begin
      step(1'b1, 32'h40, 32'(k));
      if (k == 7) chk("sat_at_max", {29'b0, wc_l}, 32'h7);
      @(negedge ph2);
    end
    chk("sat_hold", {29'b0, wc_l}, 32'h7);
    chk("sat_state", {30'b0, st_l}, 32'h1);

    // heartbeat with HB_BIT=2, then steady after PASS
    reset_dut();
    for (int k = 1; k <= 12; k++) begin
      step(1'b0, 32'h0, 32'd0);
      chk($sformatf("hb_k%0d", k), {31'b0, leds_l[0]}, {31'b0, 1'((k >> 2) & 1)});
      @(negedge ph2);
    end
    step(1'b1, 32'h14, 32'd21);
    chk("hb_pass_state", {30'b0, st_l}, 32'h2);
    chk("hb_pass_led", {31'b0, leds_l[0]}, 32'h1);
    @(negedge ph2);
    for (int k = 14; k <= 19; k++) begin
      step(1'b0, 32'h0, 32'd0);
      chk($sformatf("hb_hold_k%0d", k), {31'b0, leds_l[0]}, 32'h1);
      @(negedge ph2);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "time limit");
  end

endmodule
